// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: datapath width, register
// index width and the forwarding-source match rule.
// The datapath width defaults to 32 and can be overridden with `DATA_WIDTH.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package operand_fetch_pkg;

  localparam int XLEN      = `DATA_WIDTH;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // A producer matches a source register when it writes that register and the
  // register is not x0 (x0 is hard-wired to zero and never forwarded).
  function automatic logic src_match(input logic we, input reg_idx_t rd, input reg_idx_t rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode -> operand fetch -> execute handshake bundle.
// master: upstream/downstream environment (decode and execute).
// slave: the operand_fetch stage itself.

interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_imm;
  reg_idx_t              in_rs1;
  reg_idx_t              in_rs2;
  reg_idx_t              in_rd;
  logic                  in_reg_write;
  logic                  in_mem_read;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_op1;
  logic [DATA_WIDTH-1:0] out_op2;
  logic [DATA_WIDTH-1:0] out_imm;
  reg_idx_t              out_rd;
  logic                  out_reg_write;
  logic                  out_mem_read;

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_reg_write, in_mem_read,
    input  in_ready,
    input  out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_reg_write, out_mem_read,
    output out_ready
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_reg_write, in_mem_read,
    output in_ready,
    output out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_reg_write, out_mem_read,
    input  out_ready
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding select and hazard detection.
// With OPERAND_FETCH_FORWARD_EN defined, the highest-priority matching producer
// (EX > MEM > WB) supplies the operand, and a hazard is raised only if that
// producer's result is not yet available. Without it, operands always come
// from the register file and any matching producer is a hazard.

module operand_fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  reg_idx_t              rs,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  input  reg_idx_t              ex_rd,
  input  reg_idx_t              mem_rd,
  input  reg_idx_t              wb_rd,
  input  logic                  ex_we,
  input  logic                  mem_we,
  input  logic                  wb_we,
  input  logic                  ex_dvalid,
  input  logic                  mem_dvalid,
  input  logic                  wb_dvalid,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  hazard
);

`ifdef OPERAND_FETCH_FORWARD_EN

  // Priority chain: the youngest producer of the register wins.
  always_comb begin
    operand = rf_rdata;
    hazard  = 1'b0;
    if (src_match(ex_we, ex_rd, rs)) begin
      operand = ex_data;
      hazard  = !ex_dvalid;
    end else if (src_match(mem_we, mem_rd, rs)) begin
      operand = mem_data;
      hazard  = !mem_dvalid;
    end else if (src_match(wb_we, wb_rd, rs)) begin
      operand = wb_data;
      hazard  = !wb_dvalid;
    end
  end

`else

  // No bypass network: wait until no in-flight producer targets this register.
  always_comb begin
    operand = rf_rdata;
    hazard  = src_match(ex_we, ex_rd, rs) || src_match(mem_we, mem_rd, rs) ||
              src_match(wb_we, wb_rd, rs);
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_data, mem_data, wb_data, ex_dvalid, mem_dvalid, wb_dvalid};

`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage (ID/EX boundary): reads the register file, resolves
// operands through the forwarding muxes, stalls on unresolved hazards and
// registers the payload for execute. Forwarding is enabled by defining
// OPERAND_FETCH_FORWARD_EN; the default build stalls instead of bypassing.

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_fetch_if.slave        bus,
  input  logic                  flush,
  output reg_idx_t              rf_raddr1,
  output reg_idx_t              rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  reg_idx_t              ex_rd,
  input  reg_idx_t              mem_rd,
  input  reg_idx_t              wb_rd,
  input  logic                  ex_we,
  input  logic                  mem_we,
  input  logic                  wb_we,
  input  logic                  ex_dvalid,
  input  logic                  mem_dvalid,
  input  logic                  wb_dvalid,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [31:0]           stall_cnt
);

  logic [DATA_WIDTH-1:0] op1_sel, op2_sel;
  logic                  op1_hazard, op2_hazard, hazard;
  logic                  in_ready, accept;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_op1_q, out_op1_d;
  logic [DATA_WIDTH-1:0] out_op2_q, out_op2_d;
  logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d;
  reg_idx_t              out_rd_q, out_rd_d;
  logic                  out_reg_write_q, out_reg_write_d;
  logic                  out_mem_read_q, out_mem_read_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;

  assign rf_raddr1 = bus.in_rs1;
  assign rf_raddr2 = bus.in_rs2;

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_op1 (
    .rs(bus.in_rs1), .rf_rdata(rf_rdata1),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_dvalid(ex_dvalid), .mem_dvalid(mem_dvalid), .wb_dvalid(wb_dvalid),
    .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .operand(op1_sel), .hazard(op1_hazard)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_op2 (
    .rs(bus.in_rs2), .rf_rdata(rf_rdata2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_dvalid(ex_dvalid), .mem_dvalid(mem_dvalid), .wb_dvalid(wb_dvalid),
    .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .operand(op2_sel), .hazard(op2_hazard)
  );

  assign hazard   = op1_hazard || op2_hazard;
  assign in_ready = !flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.out_op1       = out_op1_q;
  assign bus.out_op2       = out_op2_q;
  assign bus.out_imm       = out_imm_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_reg_write = out_reg_write_q;
  assign bus.out_mem_read  = out_mem_read_q;
  assign stall_cnt         = stall_cnt_q;

  // Next-state: load payload on accept, drop valid when drained or flushed,
  // otherwise hold everything so execute sees a stable payload.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_pc_d        = out_pc_q;
    out_op1_d       = out_op1_q;
    out_op2_d       = out_op2_q;
    out_imm_d       = out_imm_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    stall_cnt_d     = stall_cnt_q;

    if (accept) begin
      out_valid_d     = 1'b1;
      out_pc_d        = bus.in_pc;
      out_op1_d       = op1_sel;
      out_op2_d       = op2_sel;
      out_imm_d       = bus.in_imm;
      out_rd_d        = bus.in_rd;
      out_reg_write_d = bus.in_reg_write;
      out_mem_read_d  = bus.in_mem_read;
    end else if (flush || bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bus.in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Pipeline register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_op1_q       <= '0;
      out_op2_q       <= '0;
      out_imm_q       <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_op1_q       <= out_op1_d;
      out_op2_q       <= out_op2_d;
      out_imm_q       <= out_imm_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// behavioural model of the stage. Honours OPERAND_FETCH_FORWARD_EN.

module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_WIDTH(DW)) bus_if ();

  logic          flush;
  logic [4:0]    rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [4:0]    ex_rd, mem_rd, wb_rd;
  logic          ex_we, mem_we, wb_we;
  logic          ex_dvalid, mem_dvalid, wb_dvalid;
  logic [DW-1:0] ex_data, mem_data, wb_data;
  logic [31:0]   stall_cnt;

  logic [DW-1:0] rf [32];

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? '0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? '0 : rf[rf_raddr2];

  operand_fetch #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_dvalid(ex_dvalid), .mem_dvalid(mem_dvalid), .wb_dvalid(wb_dvalid),
    .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_pc = '0, m_op1 = '0, m_op2 = '0, m_imm = '0;
  logic [4:0]    m_rd = '0;
  logic          m_rw = 1'b0, m_mr = 1'b0;
  logic [31:0]   m_stall = '0;

  logic [DW-1:0] mv1, mv2;
  bit            mh1, mh2, mrdy;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Resolve one source operand from the spec rules: scan producers youngest
  // first, stop at the first one that writes this (non-zero) register.
  function automatic void resolve(input logic [4:0] rs, output logic [DW-1:0] val, output bit haz);
    logic [4:0]    s_rd [3];
    logic          s_we [3];
    logic          s_dv [3];
    logic [DW-1:0] s_dt [3];
    s_rd[0] = ex_rd;     s_rd[1] = mem_rd;     s_rd[2] = wb_rd;
    s_we[0] = ex_we;     s_we[1] = mem_we;     s_we[2] = wb_we;
    s_dv[0] = ex_dvalid; s_dv[1] = mem_dvalid; s_dv[2] = wb_dvalid;
    s_dt[0] = ex_data;   s_dt[1] = mem_data;   s_dt[2] = wb_data;
    val = (rs == 5'd0) ? '0 : rf[rs];
    haz = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s_we[s] === 1'b1 && s_rd[s] == rs && rs != 5'd0) begin
`ifdef OPERAND_FETCH_FORWARD_EN
        haz = !s_dv[s];
        val = s_dt[s];
`else
        haz = 1'b1;
`endif
        break;
      end
    end
  endfunction

  function automatic bit exp_ready();
    logic [DW-1:0] v1, v2;
    bit h1, h2;
    resolve(bus_if.in_rs1, v1, h1);
    resolve(bus_if.in_rs2, v2, h2);
    return !flush && !h1 && !h2 && (!m_valid || bus_if.out_ready);
  endfunction

  // Model advance on each clock edge; cleared by the asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_imm = '0;
      m_rd = '0; m_rw = 1'b0; m_mr = 1'b0; m_stall = '0;
    end else begin
      resolve(bus_if.in_rs1, mv1, mh1);
      resolve(bus_if.in_rs2, mv2, mh2);
      mrdy = !flush && !mh1 && !mh2 && (!m_valid || bus_if.out_ready);
      if (bus_if.in_valid && (mh1 || mh2) && !flush && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 1;
      if (bus_if.in_valid && mrdy) begin
        m_valid = 1'b1;
        m_pc  = bus_if.in_pc;  m_imm = bus_if.in_imm;
        m_op1 = mv1;           m_op2 = mv2;
        m_rd  = bus_if.in_rd;  m_rw  = bus_if.in_reg_write; m_mr = bus_if.in_mem_read;
      end else if (flush || bus_if.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("rf_raddr1", rf_raddr1, bus_if.in_rs1);
      checkOutput("rf_raddr2", rf_raddr2, bus_if.in_rs2);
      checkOutput("in_ready", bus_if.in_ready, exp_ready());
      checkOutput("out_valid", bus_if.out_valid, m_valid);
      checkOutput("out_pc", bus_if.out_pc, m_pc);
      checkOutput("out_op1", bus_if.out_op1, m_op1);
      checkOutput("out_op2", bus_if.out_op2, m_op2);
      checkOutput("out_imm", bus_if.out_imm, m_imm);
      checkOutput("out_rd", bus_if.out_rd, m_rd);
      checkOutput("out_reg_write", bus_if.out_reg_write, m_rw);
      checkOutput("out_mem_read", bus_if.out_mem_read, m_mr);
      checkOutput("stall_cnt", stall_cnt, m_stall);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.in_valid = 1'b0; bus_if.in_pc = '0; bus_if.in_imm = '0;
    bus_if.in_rs1 = '0; bus_if.in_rs2 = '0; bus_if.in_rd = '0;
    bus_if.in_reg_write = 1'b0; bus_if.in_mem_read = 1'b0;
    bus_if.out_ready = 1'b1; flush = 1'b0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
    ex_dvalid = 1'b1; mem_dvalid = 1'b1; wb_dvalid = 1'b1;
    ex_data = '0; mem_data = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus();
    bus_if.in_valid     = ($urandom_range(0, 3) != 0);
    bus_if.in_pc        = $urandom;
    bus_if.in_imm       = $urandom;
    bus_if.in_rs1       = 5'($urandom_range(0, 7));
    bus_if.in_rs2       = 5'($urandom_range(0, 7));
    bus_if.in_rd        = 5'($urandom_range(0, 31));
    bus_if.in_reg_write = 1'($urandom_range(0, 1));
    bus_if.in_mem_read  = 1'($urandom_range(0, 1));
    bus_if.out_ready    = ($urandom_range(0, 3) != 0);
    flush               = ($urandom_range(0, 15) == 0);
    ex_rd  = 5'($urandom_range(0, 7)); ex_we  = ($urandom_range(0, 2) == 0);
    mem_rd = 5'($urandom_range(0, 7)); mem_we = ($urandom_range(0, 2) == 0);
    wb_rd  = 5'($urandom_range(0, 7)); wb_we  = ($urandom_range(0, 2) == 0);
    ex_dvalid  = ($urandom_range(0, 3) != 0);
    mem_dvalid = ($urandom_range(0, 3) != 0);
    wb_dvalid  = ($urandom_range(0, 3) != 0);
    ex_data = $urandom; mem_data = $urandom; wb_data = $urandom;
    if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 31)] = $urandom;
  endtask

  initial begin
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    clear_inputs();
    rst_n = 1'b0;
    step();
    check_en = 1'b1;
    step();

    // Reset state
    checkOutput("reset_out_valid", bus_if.out_valid, 1'b0);
    checkOutput("reset_out_pc", bus_if.out_pc, 32'h0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'h0);
    checkOutput("reset_in_ready", bus_if.in_ready, 1'b1);
    rst_n = 1'b1;

    // x0 is never forwarded and never a hazard
    step();
    bus_if.in_valid = 1'b1; bus_if.in_pc = 32'h40; bus_if.in_rs1 = 5'd0;
    ex_rd = 5'd0; ex_we = 1'b1; ex_dvalid = 1'b1; ex_data = 32'hFFFF;
    #1 checkOutput("x0_in_ready", bus_if.in_ready, 1'b1);
    step();
    bus_if.in_valid = 1'b0;
    checkOutput("x0_out_valid", bus_if.out_valid, 1'b1);
    checkOutput("x0_out_op1", bus_if.out_op1, 32'h0);
    clear_inputs();

    // Forwarding priority EX > MEM > WB
    step();
    bus_if.in_rs1 = 5'd5;
    ex_rd = 5'd5;  ex_we = 1'b1;  ex_data = 32'h11;
    mem_rd = 5'd5; mem_we = 1'b1; mem_data = 32'h22;
    wb_rd = 5'd5;  wb_we = 1'b1;  wb_data = 32'h33;
`ifdef OPERAND_FETCH_FORWARD_EN
    bus_if.in_valid = 1'b1;
    #1 checkOutput("prio_in_ready", bus_if.in_ready, 1'b1);
    step();
    bus_if.in_valid = 1'b0;
    checkOutput("prio_out_valid", bus_if.out_valid, 1'b1);
    checkOutput("prio_out_op1", bus_if.out_op1, 32'h11);
`else
    #1 checkOutput("prio_in_ready", bus_if.in_ready, 1'b0);
`endif
    clear_inputs();
    step();

    // Load-use stall
    do_reset();
    bus_if.in_valid = 1'b1; bus_if.in_rs2 = 5'd7;
    ex_rd = 5'd7; ex_we = 1'b1; ex_dvalid = 1'b0;
    #1 checkOutput("lu_in_ready", bus_if.in_ready, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput("lu_stall_cnt", stall_cnt, 64'(i));
      checkOutput("lu_out_valid", bus_if.out_valid, 1'b0);
    end
    ex_we = 1'b0;
    mem_rd = 5'd7; mem_we = 1'b1; mem_dvalid = 1'b1; mem_data = 32'hABCD;
`ifdef OPERAND_FETCH_FORWARD_EN
    #1 checkOutput("lu_release_ready", bus_if.in_ready, 1'b1);
    step();
    checkOutput("lu_out_valid_after", bus_if.out_valid, 1'b1);
    checkOutput("lu_out_op2", bus_if.out_op2, 32'hABCD);
    checkOutput("lu_stall_final", stall_cnt, 32'd3);
`else
    #1 checkOutput("lu_release_ready", bus_if.in_ready, 1'b0);
    step();
    checkOutput("lu_stall_final", stall_cnt, 32'd4);
`endif
    clear_inputs();
    step();

    // Stall counter saturation
    bus_if.in_valid = 1'b1; bus_if.in_rs1 = 5'd4;
    ex_rd = 5'd4; ex_we = 1'b1; ex_dvalid = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    step();
    checkOutput("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    step();
    checkOutput("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    clear_inputs();
    do_reset();

    // WB producer match
    bus_if.in_valid = 1'b1; bus_if.in_rs1 = 5'd3;
    wb_rd = 5'd3; wb_we = 1'b1; wb_dvalid = 1'b1; wb_data = 32'h3333;
`ifdef OPERAND_FETCH_FORWARD_EN
    #1 checkOutput("wb_in_ready", bus_if.in_ready, 1'b1);
    step();
    checkOutput("wb_out_valid", bus_if.out_valid, 1'b1);
    checkOutput("wb_out_op1", bus_if.out_op1, 32'h3333);
`else
    #1 checkOutput("wb_in_ready", bus_if.in_ready, 1'b0);
    step();
    checkOutput("wb_out_valid_held", bus_if.out_valid, 1'b0);
    step();
    checkOutput("wb_out_valid_held", bus_if.out_valid, 1'b0);
    wb_we = 1'b0;
    #1 checkOutput("wb_clear_ready", bus_if.in_ready, 1'b1);
    step();
    checkOutput("wb_out_valid", bus_if.out_valid, 1'b1);
    checkOutput("wb_out_op1", bus_if.out_op1, rf[3]);
`endif
    clear_inputs();
    step();

    // Backpressure
    bus_if.in_valid = 1'b1; bus_if.in_pc = 32'h100; bus_if.out_ready = 1'b0;
    #1 checkOutput("bp_first_ready", bus_if.in_ready, 1'b1);
    step();
    bus_if.in_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", bus_if.in_ready, 1'b0);
      checkOutput("bp_out_valid", bus_if.out_valid, 1'b1);
      checkOutput("bp_out_pc", bus_if.out_pc, 32'h100);
      step();
    end
    bus_if.out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", bus_if.in_ready, 1'b1);
    step();
    checkOutput("bp_new_valid", bus_if.out_valid, 1'b1);
    checkOutput("bp_new_pc", bus_if.out_pc, 32'h200);

    // Flush overrides a valid request and a held output
    bus_if.out_ready = 1'b0; flush = 1'b1; bus_if.in_pc = 32'h300;
    #1 checkOutput("flush_in_ready", bus_if.in_ready, 1'b0);
    step();
    checkOutput("flush_out_valid", bus_if.out_valid, 1'b0);
    checkOutput("flush_out_pc_hold", bus_if.out_pc, 32'h200);
    flush = 1'b0; bus_if.out_ready = 1'b1; bus_if.in_pc = 32'h400;
    step();
    checkOutput("pre_rst_valid", bus_if.out_valid, 1'b1);
    checkOutput("pre_rst_pc", bus_if.out_pc, 32'h400);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", bus_if.out_valid, 1'b0);
    checkOutput("arst_stall_cnt", stall_cnt, 32'h0);
    checkOutput("arst_out_pc", bus_if.out_pc, 32'h0);
    step();
    bus_if.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_valid", bus_if.out_valid, 1'b0);
    clear_inputs();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      applyStimulus();
    end
    step();
    clear_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
